// File: rtl/modport_pattern_detector_if.sv
// Bundles the stream, mask, mode and match signals of the pattern detector.
// master: the producer/consumer side (drives streams, reads match).
// slave:  the detector itself.
interface modport_pattern_detector_if;
  logic [63:0] data_stream_a;
  logic [63:0] data_stream_b;
  logic        mode_select;
  logic [31:0] pattern_mask;
  logic        pattern_match;

  modport master (
    output data_stream_a,
    output data_stream_b,
    output mode_select,
    output pattern_mask,
    input  pattern_match
  );

  modport slave (
    input  data_stream_a,
    input  data_stream_b,
    input  mode_select,
    input  pattern_mask,
    output pattern_match
  );
endinterface

// File: rtl/modport_pattern_detector.sv
// Streaming pattern detector with a registered match flag.
//   mode 0: search five byte-aligned 32-bit windows of stream A for the
//           masked pattern B[31:0].
//   mode 1: masked Hamming distance between A and B (mask replicated onto
//           both 32-bit halves) compared against HAMMING_THRESH.
// Optional macro PATTERN_PIPE_EN inserts a register stage holding the window
// hits, the distance and the mode bit, giving 2-cycle latency instead of 1.
module modport_pattern_detector #(
  parameter int HAMMING_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,  // active-high despite the name
  modport_pattern_detector_if.slave     det
);

  logic [4:0]  hit_d;
  logic [6:0]  dist_d;
  logic [63:0] diff_masked;
  logic        match_d;
  logic        match_q;

  // Threshold test kept in signed int space so thresholds >= 64 simply always pass.
  function automatic logic dist_ok(input logic [6:0] d);
    return int'({25'd0, d}) <= HAMMING_THRESH;
  endfunction

  // Per-window masked equality against the pattern taken from B[31:0].
  always_comb begin
    hit_d = '0;
    for (int k = 0; k < 5; k++) begin
      hit_d[k] = ((det.data_stream_a[8*k +: 32] ^ det.data_stream_b[31:0])
                  & det.pattern_mask) == 32'd0;
    end
  end

  // Masked population count of A ^ B; each mask bit covers bits i and i+32.
  always_comb begin
    diff_masked = (det.data_stream_a ^ det.data_stream_b)
                  & {det.pattern_mask, det.pattern_mask};
    dist_d = '0;
    for (int i = 0; i < 64; i++) begin
      dist_d = dist_d + {6'd0, diff_masked[i]};
    end
  end

`ifdef PATTERN_PIPE_EN
  logic [4:0] hit_q;
  logic [6:0] dist_q;
  logic       mode_q;

  // Intermediate stage; cleared values (mode 0, no hits) yield a 0 match.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hit_q  <= '0;
      dist_q <= '0;
      mode_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      dist_q <= dist_d;
      mode_q <= det.mode_select;
    end
  end

  // Select the result of the mode captured alongside the intermediate values.
  always_comb begin
    match_d = 1'b0;
    if (mode_q) match_d = dist_ok(dist_q);
    else        match_d = |hit_q;
  end
`else
  // Select the result of the current mode directly from the inputs.
  always_comb begin
    match_d = 1'b0;
    if (det.mode_select) match_d = dist_ok(dist_d);
    else                 match_d = |hit_d;
  end
`endif

  // Output register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) match_q <= 1'b0;
    else       match_q <= match_d;
  end

  assign det.pattern_match = match_q;

endmodule

// File: tb/tb_modport_pattern_detector.sv
module tb_modport_pattern_detector;
  localparam int THRESH = 2;
`ifdef PATTERN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;
  bit   exp_q[$];

  modport_pattern_detector_if pif ();

  modport_pattern_detector #(.HAMMING_THRESH(THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .det   (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Reference behaviour written directly from the matching rules.
  function automatic bit model(input logic [63:0] a, input logic [63:0] b,
                               input logic m, input logic [31:0] mask);
    logic [63:0] sh;
    if (!m) begin
      for (int k = 0; k < 5; k++) begin
        sh = a >> (8 * k);
        if (((sh[31:0] ^ b[31:0]) & mask) == 32'd0) return 1'b1;
      end
      return 1'b0;
    end
    return $countones((a ^ b) & {mask, mask}) <= THRESH;
  endfunction

  // Apply one vector, clock it in, and compare against the result due now.
  task automatic cycle(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic m, input logic [31:0] mask);
    pif.data_stream_a = a;
    pif.data_stream_b = b;
    pif.mode_select   = m;
    pif.pattern_mask  = mask;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b, m, mask));
    if (exp_q.size() > LAT) void'(exp_q.pop_front());
    if (exp_q.size() == LAT) chk(tag, pif.pattern_match, exp_q[0]);
  endtask

  initial begin
    logic [63:0] a, b, sh;
    logic [31:0] mask;
    logic        m;
    int          k;

    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b1;
    pif.data_stream_a = '0;
    pif.data_stream_b = '0;
    pif.mode_select   = 1'b0;
    pif.pattern_mask  = '0;

    // Reset held with arbitrary inputs: output stays 0.
    for (int i = 0; i < 3; i++) begin
      pif.data_stream_a = {$urandom, $urandom};
      pif.data_stream_b = pif.data_stream_a;
      pif.mode_select   = 1'(i);
      pif.pattern_mask  = 32'h0;
      @(posedge clk);
      #1;
      chk("reset_hold", pif.pattern_match, 1'b0);
    end
    rst_n = 1'b0;
    exp_q.delete();

    // Directed cases.
    cycle("m0_off4",    64'hDEADBEEF_00000000, 64'h0_DEADBEEF, 1'b0, 32'hFFFFFFFF);
    cycle("m0_off0",    64'h00000000_DEADBEEF, 64'h0_DEADBEEF, 1'b0, 32'hFFFFFFFF);
    cycle("m0_miss",    64'h0, 64'h0000_00FF, 1'b0, 32'hFFFFFFFF);
    cycle("m0_masked",  64'h0, 64'h0000_00FF, 1'b0, 32'hFFFFFF00);
    cycle("m1_d2",      64'h0, 64'h3, 1'b1, 32'hFFFFFFFF);
    cycle("m1_d3",      64'h0, 64'h7, 1'b1, 32'hFFFFFFFF);
    cycle("m1_d2_mask", 64'h0, 64'h7, 1'b1, 32'hFFFFFFFE);
    cycle("m1_upper",   64'h0, 64'h0000000F_00000000, 1'b1, 32'h0000000F);
    cycle("m1_mask0",   64'h0, 64'h0000000F_00000000, 1'b1, 32'h0);
    cycle("m0_mask0",   64'h0123_4567_89AB_CDEF, 64'h5555_AAAA, 1'b0, 32'h0);
    cycle("m0_off2",    64'h0000_CAFEF00D_0000, 64'hFFFF_FFFF_CAFEF00D, 1'b0, 32'hFFFFFFFF);
    // Back-to-back mode toggling: expected 1,0,0,1.
    cycle("tog_m0_hit",  64'h11223344_55667788, 64'h33445566, 1'b0, 32'hFFFFFFFF);
    cycle("tog_m1_miss", 64'h0, 64'hF0, 1'b1, 32'hFFFFFFFF);
    cycle("tog_m0_miss", 64'h11223344_55667788, 64'h12345678, 1'b0, 32'hFFFFFFFF);
    cycle("tog_m1_hit",  64'h8000_0000_0000_0001, 64'h0, 1'b1, 32'hFFFFFFFF);

    // Asynchronous reset mid-cycle while the match flag is high.
    for (int i = 0; i < LAT; i++) cycle("pre_async", 64'h0, 64'h1, 1'b0, 32'h0);
    chk("pre_async_high", pif.pattern_match, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_reset", pif.pattern_match, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();

    // Randomized traffic with biasing toward hits and near-threshold distances.
    for (int n = 0; n < 400; n++) begin
      a = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom)
           : ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
      if (!m) begin
        b = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          k  = $urandom_range(0, 4);
          sh = a >> (8 * k);
          b[31:0] = sh[31:0];
          if ($urandom_range(0, 2) == 0) b[$urandom_range(0, 31)] ^= 1'b1;
        end
      end else begin
        b = a;
        for (int j = 0; j < int'($urandom_range(0, 5)); j++)
          b = b ^ (64'd1 << $urandom_range(0, 63));
      end
      cycle("random", a, b, m, mask);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
